mips_test_sequencer: RTL and testbench

Synthesisable self-checking test sequencer for the 5-stage MIPS core. For each of NUM_TESTS programs it clears the register file, loads the program into instruction memory from a program ROM, and releases the core from reset. It then waits for HALTED or a timeout and compares selected registers against an expected-value ROM. It sits beside the core and its clock wizard, replacing hierarchical pokes with real write/read ports, so the same regression runs in simulation and on the board.

---
 rtl/mips_test_sequencer.sv | 252 +++++++++++++++++++++++++
 tb/tb_mips_test_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_test_sequencer.sv
// mips_test_sequencer
//
// Self-checking regression sequencer that sits beside the 5-stage MIPS core.
// For each of NUM_TESTS programs it clears the register file, copies the
// program from a program ROM into instruction memory, releases the core from
// reset, waits for HALTED (or a timeout) and then compares selected registers
// against an expected-value ROM.
//
// Ports
//   clk_in, reset        : clock and synchronous active-high reset
//   clk_locked           : clock wizard lock; losing it aborts a running sequence
//   start                : one-cycle pulse that begins a sequence (IDLE/DONE only)
//   cpu_halted           : HALTED flag from the core
//   cpu_reset            : reset to the core, low only while it runs or is checked
//   imem_we/addr/wdata   : instruction memory write port
//   rf_we/addr/wdata     : register file write port; rf_addr also drives the
//                          asynchronous read that returns rf_rdata
//   prog_rom_addr/data   : program ROM, data one cycle after address
//   chk_rom_addr/data    : expected ROM {valid, reg_idx[4:0], value}, one-cycle read
//   busy/done/pass       : sequence status
//   fail_mask/fail_count : per-test failure bits and saturating mismatch count
//   timeout_flag/aborted : any test hung / lock lost mid-sequence
//   cur_test, run_cycles : test index and RUN length of the most recent test
module mips_test_sequencer #(
    parameter int DATA_W     = 32,
    parameter int IMEM_AW    = 5,
    parameter int PROG_DEPTH = 8,
    parameter int NUM_TESTS  = 2,
    parameter int NUM_CHECKS = 6,
    parameter int TIMEOUT    = 1024,
    parameter int RST_CYCLES = 2,
    localparam int PA_W = (NUM_TESTS * PROG_DEPTH > 1) ? $clog2(NUM_TESTS * PROG_DEPTH) : 1,
    localparam int CA_W = (NUM_TESTS * NUM_CHECKS > 1) ? $clog2(NUM_TESTS * NUM_CHECKS) : 1,
    localparam int T_W  = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 clk_locked,
    input  logic                 start,
    input  logic                 cpu_halted,
    output logic                 cpu_reset,
    output logic                 imem_we,
    output logic [IMEM_AW-1:0]   imem_addr,
    output logic [DATA_W-1:0]    imem_wdata,
    output logic                 rf_we,
    output logic [4:0]           rf_addr,
    output logic [DATA_W-1:0]    rf_wdata,
    input  logic [DATA_W-1:0]    rf_rdata,
    output logic [PA_W-1:0]      prog_rom_addr,
    input  logic [DATA_W-1:0]    prog_rom_data,
    output logic [CA_W-1:0]      chk_rom_addr,
    input  logic [DATA_W+5:0]    chk_rom_data,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [NUM_TESTS-1:0] fail_mask,
    output logic [7:0]           fail_count,
    output logic                 timeout_flag,
    output logic                 aborted,
    output logic [T_W-1:0]       cur_test,
    output logic [15:0]          run_cycles
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLR     = 3'd1;
    localparam logic [2:0] S_LOAD    = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_RUN     = 3'd4;
    localparam logic [2:0] S_CHECK   = 3'd5;
    localparam logic [2:0] S_NEXT    = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    logic [2:0]           state_q, state_d;
    logic [31:0]          cnt_q, cnt_d;
    logic [T_W-1:0]       cur_test_q, cur_test_d;
    logic [NUM_TESTS-1:0] fail_mask_q, fail_mask_d;
    logic [7:0]           fail_count_q, fail_count_d;
    logic                 timeout_q, timeout_d;
    logic                 aborted_q, aborted_d;
    logic [15:0]          run_cycles_q, run_cycles_d;

    logic [31:0]          run_n;
    logic                 chk_valid;
    logic [4:0]           chk_idx;
    logic [DATA_W-1:0]    chk_val;

    assign chk_valid = chk_rom_data[DATA_W+5];
    assign chk_idx   = chk_rom_data[DATA_W+4:DATA_W];
    assign chk_val   = chk_rom_data[DATA_W-1:0];

    // RUN cycles elapsed including the current one
    assign run_n = cnt_q + 32'd1;

    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign pass      = (state_q == S_DONE) && (fail_mask_q == '0);
    // The core only leaves reset while running its program and while its
    // registers are being checked, so the write ports never race it.
    assign cpu_reset = !((state_q == S_RUN) || (state_q == S_CHECK));
    assign rf_wdata  = '0;

    assign fail_mask    = fail_mask_q;
    assign fail_count   = fail_count_q;
    assign timeout_flag = timeout_q;
    assign aborted      = aborted_q;
    assign cur_test     = cur_test_q;
    assign run_cycles   = run_cycles_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cur_test_d    = cur_test_q;
        fail_mask_d   = fail_mask_q;
        fail_count_d  = fail_count_q;
        timeout_d     = timeout_q;
        aborted_d     = aborted_q;
        run_cycles_d  = run_cycles_q;
        imem_we       = 1'b0;
        imem_addr     = '0;
        imem_wdata    = '0;
        rf_we         = 1'b0;
        rf_addr       = '0;
        prog_rom_addr = '0;
        chk_rom_addr  = '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start && clk_locked) begin
                    state_d      = S_CLR;
                    cnt_d        = '0;
                    cur_test_d   = '0;
                    fail_mask_d  = '0;
                    fail_count_d = '0;
                    timeout_d    = 1'b0;
                    aborted_d    = 1'b0;
                end
            end
            S_CLR: begin
                rf_we   = 1'b1;
                rf_addr = cnt_q[4:0];
                if (cnt_q == 32'd31) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_LOAD: begin
                // Address issued at count k, ROM data written at count k+1.
                if (cnt_q < PROG_DEPTH) begin
                    prog_rom_addr = PA_W'(cur_test_q) * PA_W'(PROG_DEPTH) + PA_W'(cnt_q);
                end
                if (cnt_q != 32'd0) begin
                    imem_we    = 1'b1;
                    imem_addr  = IMEM_AW'(cnt_q - 32'd1);
                    imem_wdata = prog_rom_data;
                end
                if (cnt_q == PROG_DEPTH) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_RELEASE: begin
                if (cnt_q >= RST_CYCLES - 1) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_RUN: begin
                // A halt arriving on the timeout cycle still counts as a halt.
                if (cpu_halted) begin
                    run_cycles_d = (run_n > 32'd65535) ? 16'hFFFF : run_n[15:0];
                    state_d      = S_CHECK;
                    cnt_d        = '0;
                end else if (run_n >= TIMEOUT) begin
                    run_cycles_d            = (run_n > 32'd65535) ? 16'hFFFF : run_n[15:0];
                    timeout_d               = 1'b1;
                    fail_mask_d[cur_test_q] = 1'b1;
                    state_d                 = S_NEXT;
                    cnt_d                   = '0;
                end else begin
                    cnt_d = run_n;
                end
            end
            S_CHECK: begin
                if (cnt_q < NUM_CHECKS) begin
                    chk_rom_addr = CA_W'(cur_test_q) * CA_W'(NUM_CHECKS) + CA_W'(cnt_q);
                end
                if (cnt_q != 32'd0) begin
                    rf_addr = chk_idx;
                    if (chk_valid && (rf_rdata != chk_val)) begin
                        fail_mask_d[cur_test_q] = 1'b1;
                        if (fail_count_q != 8'hFF) begin
                            fail_count_d = fail_count_q + 8'd1;
                        end
                    end
                end
                if (cnt_q == NUM_CHECKS) begin
                    state_d = S_NEXT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_NEXT: begin
                if (cur_test_q == T_W'(NUM_TESTS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    cur_test_d = cur_test_q + T_W'(1);
                    state_d    = S_CLR;
                end
                cnt_d = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Losing the clock lock mid-sequence abandons it entirely.
        if (busy && !clk_locked) begin
            state_d   = S_IDLE;
            aborted_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            cur_test_q   <= '0;
            fail_mask_q  <= '0;
            fail_count_q <= '0;
            timeout_q    <= 1'b0;
            aborted_q    <= 1'b0;
            run_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cur_test_q   <= cur_test_d;
            fail_mask_q  <= fail_mask_d;
            fail_count_q <= fail_count_d;
            timeout_q    <= timeout_d;
            aborted_q    <= aborted_d;
            run_cycles_q <= run_cycles_d;
        end
    end

endmodule

// File: tb/tb_mips_test_sequencer.sv
// Bench for mips_test_sequencer. Provides the program/expected ROMs, the
// register file, instruction memory and a small behavioural core running the
// test ISA (addi 0x0A, add 0x00, bne 0x0D, halt 0x3F). Expected sequence
// results come from an ISA-level interpreter of each program.
module tb_mips_test_sequencer;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int PD = 8;
    localparam int NT = 2;
    localparam int NC = 6;
    localparam int TO = 64;
    localparam int RC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, clk_locked, start, cpu_halted;
    logic          cpu_reset, imem_we, rf_we;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_wdata, rf_wdata, rf_rdata, prog_rom_data;
    logic [4:0]    rf_addr;
    logic [3:0]    prog_rom_addr, chk_rom_addr;
    logic [DW+5:0] chk_rom_data;
    logic          busy, done, pass, timeout_flag, aborted;
    logic [NT-1:0] fail_mask;
    logic [7:0]    fail_count;
    logic [0:0]    cur_test;
    logic [15:0]   run_cycles;

    mips_test_sequencer #(
        .DATA_W(DW), .IMEM_AW(AW), .PROG_DEPTH(PD), .NUM_TESTS(NT),
        .NUM_CHECKS(NC), .TIMEOUT(TO), .RST_CYCLES(RC)
    ) dut (
        .clk_in(clk), .reset(reset), .clk_locked(clk_locked), .start(start),
        .cpu_halted(cpu_halted), .cpu_reset(cpu_reset),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
        .prog_rom_addr(prog_rom_addr), .prog_rom_data(prog_rom_data),
        .chk_rom_addr(chk_rom_addr), .chk_rom_data(chk_rom_data),
        .busy(busy), .done(done), .pass(pass), .fail_mask(fail_mask),
        .fail_count(fail_count), .timeout_flag(timeout_flag), .aborted(aborted),
        .cur_test(cur_test), .run_cycles(run_cycles)
    );

    // ---------------- environment: ROMs, memories, core ----------------
    logic [DW-1:0]   prog_mem [16];
    logic [DW+5:0]   chk_mem  [16];
    logic [DW-1:0]   rf       [32];
    logic [DW-1:0]   imem     [32];
    logic [31:0]     pc;
    logic            core_halted;
    logic            no_halt;
    logic [DW-1:0]   c_ins, c_imm;

    always @(posedge clk) begin
        prog_rom_data <= prog_mem[prog_rom_addr];
        chk_rom_data  <= chk_mem[chk_rom_addr];
    end

    assign rf_rdata   = rf[rf_addr];
    assign cpu_halted = core_halted & ~no_halt;

    always @(posedge clk) begin
        if (imem_we) imem[imem_addr] <= imem_wdata;
        if (rf_we)   rf[rf_addr]     <= rf_wdata;
        if (cpu_reset) begin
            pc          <= 32'd0;
            core_halted <= 1'b0;
        end else if (!core_halted) begin
            c_ins = imem[pc[4:0]];
            c_imm = {{16{c_ins[15]}}, c_ins[15:0]};
            case (c_ins[31:26])
                6'h0A: begin
                    if (c_ins[20:16] != 5'd0) rf[c_ins[20:16]] <= rf[c_ins[25:21]] + c_imm;
                    pc <= pc + 32'd1;
                end
                6'h00: begin
                    if (c_ins[15:11] != 5'd0) rf[c_ins[15:11]] <= rf[c_ins[25:21]] + rf[c_ins[20:16]];
                    pc <= pc + 32'd1;
                end
                6'h0D: pc <= (rf[c_ins[25:21]] != rf[c_ins[20:16]]) ? pc + 32'd1 + c_imm : pc + 32'd1;
                6'h3F: core_halted <= 1'b1;
                default: pc <= pc + 32'd1;
            endcase
        end
    end

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] ref_regs [32];
    int            ref_steps;
    bit            ref_halt;
    int            exp_run [NT];
    logic [NT-1:0] exp_mask;
    int            exp_cnt;
    bit            exp_to;

    // Executes program t to completion from a cleared register file.
    task automatic ref_run(input int t);
        int pcm;
        logic [31:0] ins, imm;
        pcm = 0; ref_steps = 0; ref_halt = 0;
        for (int i = 0; i < 32; i++) ref_regs[i] = '0;
        while (!ref_halt && ref_steps < 2000) begin
            ins = (pcm >= 0 && pcm < PD) ? prog_mem[t*PD + pcm] : 32'd0;
            imm = {{16{ins[15]}}, ins[15:0]};
            ref_steps++;
            case (ins[31:26])
                6'h0A: begin if (ins[20:16] != 0) ref_regs[ins[20:16]] = ref_regs[ins[25:21]] + imm; pcm++; end
                6'h00: begin if (ins[15:11] != 0) ref_regs[ins[15:11]] = ref_regs[ins[25:21]] + ref_regs[ins[20:16]]; pcm++; end
                6'h0D: pcm = (ref_regs[ins[25:21]] != ref_regs[ins[20:16]]) ? pcm + 1 + int'($signed(imm)) : pcm + 1;
                6'h3F: ref_halt = 1;
                default: pcm++;
            endcase
        end
    endtask

    task automatic compute_expect(input bit nh);
        logic [DW+5:0] e;
        exp_mask = '0; exp_cnt = 0; exp_to = 0;
        for (int t = 0; t < NT; t++) begin
            ref_run(t);
            // The halt becomes visible to the sequencer one cycle after it executes.
            if (nh || !ref_halt || ref_steps + 1 > TO) begin
                exp_to = 1; exp_mask[t] = 1'b1; exp_run[t] = TO;
            end else begin
                exp_run[t] = ref_steps + 1;
                for (int j = 0; j < NC; j++) begin
                    e = chk_mem[t*NC + j];
                    if (e[DW+5] && ref_regs[e[DW+4:DW]] != e[DW-1:0]) begin
                        exp_mask[t] = 1'b1;
                        if (exp_cnt < 255) exp_cnt++;
                    end
                end
            end
        end
    endtask

    // ---------------- per-cycle protocol checker ----------------
    logic new_seq;
    int   clr_idx = 0, wr_idx = 0, mdl_test = -1;

    always @(negedge clk) begin
        if (new_seq) begin
            clr_idx = 0; wr_idx = 0; mdl_test = -1;
        end else if (!reset) begin
            if (!cpu_reset) cmp("we_while_core_runs", {imem_we, rf_we}, 2'b00);
            cmp("busy_done_exclusive", busy & done, 1'b0);
            if (rf_we) begin
                if (clr_idx == 0) begin
                    mdl_test++;
                    wr_idx = 0;
                    cmp("cur_test_step", cur_test, mdl_test);
                    if (mdl_test >= 1 && mdl_test <= NT) cmp("run_cycles_prev", run_cycles, exp_run[mdl_test-1]);
                end
                cmp("rf_clear_addr", rf_addr, clr_idx);
                cmp("rf_clear_data", rf_wdata, 0);
                clr_idx = (clr_idx + 1) % 32;
            end
            if (imem_we) begin
                cmp("imem_addr", imem_addr, wr_idx);
                cmp("imem_data", imem_wdata,
                    prog_mem[((mdl_test < 0 ? 0 : mdl_test) * PD + wr_idx) % (NT*PD)]);
                wr_idx++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; new_seq = 1'b1;
        tick(1);
        start = 1'b0; new_seq = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            // Stray starts while busy must be ignored.
            start = busy && ($urandom_range(0, 30) == 0);
            tick(1);
            k++;
        end
        start = 1'b0;
        cmp("done_reached", done, 1'b1);
    endtask

    task automatic run_seq(input bit nh);
        compute_expect(nh);
        no_halt = nh;
        tick($urandom_range(1, 4));
        pulse_start();
        wait_done(2000);
        cmp("seq_fail_mask", fail_mask, exp_mask);
        cmp("seq_fail_count", fail_count, exp_cnt);
        cmp("seq_pass", pass, (exp_mask == 0));
        cmp("seq_timeout", timeout_flag, exp_to);
        cmp("seq_aborted", aborted, 1'b0);
        cmp("seq_busy", busy, 1'b0);
        cmp("seq_cpu_reset", cpu_reset, 1'b1);
        cmp("seq_cur_test", cur_test, NT - 1);
        cmp("seq_run_cycles", run_cycles, exp_run[NT-1]);
    endtask

    task automatic load_spec();
        for (int i = 0; i < 16; i++) begin prog_mem[i] = '0; chk_mem[i] = '0; end
        prog_mem[0] = 32'h2801000a; prog_mem[1] = 32'h28020014; prog_mem[2] = 32'h28030019;
        prog_mem[3] = 32'h00222000; prog_mem[4] = 32'h00832800; prog_mem[5] = 32'hfc000000;
        prog_mem[8]  = 32'h280A0005; prog_mem[9]  = 32'h280B0000; prog_mem[10] = 32'h296B0002;
        prog_mem[11] = 32'h294AFFFF; prog_mem[12] = 32'h3540FFFD; prog_mem[13] = 32'hFC000000;
        chk_mem[0] = {1'b1, 5'd1, 32'd10};
        chk_mem[1] = {1'b1, 5'd2, 32'd20};
        chk_mem[2] = {1'b1, 5'd3, 32'd25};
        chk_mem[3] = {1'b1, 5'd4, 32'd30};
        chk_mem[4] = {1'b1, 5'd5, 32'd55};
        chk_mem[5] = {1'b0, 5'd1, 32'hDEAD};
        chk_mem[6]  = {1'b1, 5'd10, 32'd0};
        chk_mem[7]  = {1'b1, 5'd11, 32'd10};
        chk_mem[8]  = {1'b0, 5'd11, 32'd7};
        chk_mem[9]  = {1'b0, 5'd10, 32'd3};
        chk_mem[10] = {1'b0, 5'd0, 32'd123};
        chk_mem[11] = {1'b0, 5'd2, 32'd5};
    endtask

    // Random straight-line addi/add programs ending in halt, with checks
    // drawn from the interpreted result and occasionally corrupted.
    task automatic gen_random();
        int len;
        logic [31:0] v;
        for (int t = 0; t < NT; t++) begin
            len = $urandom_range(1, PD - 1);
            for (int i = 0; i < PD; i++) begin
                if (i < len) begin
                    if ($urandom_range(0, 1) == 0)
                        prog_mem[t*PD+i] = {6'h0A, 5'($urandom_range(0, 7)), 5'($urandom_range(1, 7)), 16'($urandom)};
                    else
                        prog_mem[t*PD+i] = {6'h00, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                            5'($urandom_range(1, 7)), 11'd0};
                end else if (i == len) begin
                    prog_mem[t*PD+i] = 32'hFC000000;
                end else begin
                    prog_mem[t*PD+i] = 32'd0;
                end
            end
            ref_run(t);
            for (int j = 0; j < NC; j++) begin
                chk_mem[t*NC+j][DW+4:DW] = 5'($urandom_range(0, 7));
                if ($urandom_range(0, 3) != 0) begin
                    v = ref_regs[chk_mem[t*NC+j][DW+4:DW]];
                    if ($urandom_range(0, 3) == 0) v = v ^ (32'd1 << $urandom_range(0, 31));
                    chk_mem[t*NC+j][DW+5]     = 1'b1;
                    chk_mem[t*NC+j][DW-1:0]   = v;
                end else begin
                    chk_mem[t*NC+j][DW+5]     = 1'b0;
                    chk_mem[t*NC+j][DW-1:0]   = $urandom;
                end
            end
        end
    endtask

    initial begin
        int k;
        reset = 1'b1; clk_locked = 1'b1; start = 1'b0; no_halt = 1'b0; new_seq = 1'b0;
        load_spec();
        tick(3);
        cmp("rst_cpu_reset", cpu_reset, 1'b1);
        cmp("rst_outputs", {busy, done, pass, timeout_flag, aborted, imem_we, rf_we}, 7'd0);
        cmp("rst_fail", {fail_mask, fail_count}, 10'd0);
        cmp("rst_cur_run", {cur_test, run_cycles}, 17'd0);
        reset = 1'b0;
        tick(2);

        // Spec programs, both pass.
        run_seq(1'b0);
        cmp("pin_model_run0", exp_run[0], 7);
        cmp("pin_model_run1", exp_run[1], 19);
        cmp("spec_pass", pass, 1'b1);
        cmp("spec_mask", fail_mask, 2'b00);
        cmp("spec_count", fail_count, 8'd0);
        cmp("spec_run1", run_cycles, 16'd19);

        // Corrupted expectation for R5.
        chk_mem[4][DW-1:0] = 32'd56;
        run_seq(1'b0);
        cmp("corrupt_mask", fail_mask, 2'b01);
        cmp("corrupt_count", fail_count, 8'd1);
        cmp("corrupt_pass", pass, 1'b0);
        chk_mem[4][DW-1:0] = 32'd55;

        // Core never reports halt.
        run_seq(1'b1);
        cmp("to_flag", timeout_flag, 1'b1);
        cmp("to_mask", fail_mask, 2'b11);
        cmp("to_run", run_cycles, 16'd64);
        cmp("to_done", done, 1'b1);
        no_halt = 1'b0;

        // Reset while writing instruction word 3.
        pulse_start();
        k = 0;
        while (!(imem_we && imem_addr == 3) && k < 300) begin tick(1); k++; end
        cmp("reach_load3", imem_we && imem_addr == 3, 1'b1);
        reset = 1'b1;
        tick(1);
        cmp("midload_imem_we", imem_we, 1'b0);
        cmp("midload_cpu_reset", cpu_reset, 1'b1);
        cmp("midload_busy_done", {busy, done}, 2'b00);
        reset = 1'b0;
        tick(1);
        run_seq(1'b0);
        cmp("after_reset_pass", pass, 1'b1);

        // Lock lost while the core runs.
        pulse_start();
        k = 0;
        while (cpu_reset && k < 300) begin tick(1); k++; end
        cmp("reach_run", cpu_reset, 1'b0);
        clk_locked = 1'b0;
        tick(1);
        cmp("abort_flag", aborted, 1'b1);
        cmp("abort_cpu_reset", cpu_reset, 1'b1);
        cmp("abort_busy_done", {busy, done}, 2'b00);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(3);
        cmp("unlocked_start_ignored", {busy, done, aborted}, 3'b001);
        clk_locked = 1'b1;
        tick(1);
        run_seq(1'b0);
        cmp("after_abort_pass", pass, 1'b1);

        // Randomized programs and expectations.
        for (int r = 0; r < 10; r++) begin
            gen_random();
            run_seq($urandom_range(0, 5) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

endmodule
